// File: rtl/rgb_fade_pwm_pkg.sv
// Shared constants for the RGB fade/PWM colour sequencer: widths, FSM encodings,
// channel indices and the SB_RGBA_DRV current settings used by the wrapper.
package rgb_fade_pwm_pkg;

  localparam int PWM_BITS_DEF = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FADE = 1'b1;

  localparam int CH_RED   = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_BLUE  = 2;
  localparam int NUM_CH   = 3;

  // SB_RGBA_DRV CURRENT_MODE / RGBx_CURRENT strings for the driver instance
  localparam string RGBA_CURRENT_MODE = "0b1";
  localparam string RGBA_CUR_LOW      = "0b000001";
  localparam string RGBA_CUR_MID      = "0b000011";
  localparam string RGBA_CUR_HIGH     = "0b000111";

endpackage

// File: rtl/rgb_fade_pwm_if.sv
// Colour command channel: valid/ready handshake carrying an RGB target and a
// jump-or-fade flag.
interface rgb_fade_pwm_if
  import rgb_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_instant;
  logic [PWM_BITS-1:0] cmd_red;
  logic [PWM_BITS-1:0] cmd_green;
  logic [PWM_BITS-1:0] cmd_blue;

  modport master (
    output cmd_valid,
    output cmd_instant,
    output cmd_red,
    output cmd_green,
    output cmd_blue,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_instant,
    input  cmd_red,
    input  cmd_green,
    input  cmd_blue,
    output cmd_ready
  );

endinterface

// File: rtl/rgb_fade_pwm_compare_ch.sv
// One PWM channel: duty is shadowed at the counter wrap so a period never sees
// a mid-cycle duty change, then compared and registered for a clean output.
module pwm_compare_ch
  import rgb_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                wrap_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] active_q, active_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    active_d = wrap_i ? duty_i : active_q;
    pwm_d    = (pwm_cnt_i < active_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB colour sequencer: accepts target colours, ramps each channel one step per
// prescaler tick, and drives three glitch-free PWM enables for SB_RGBA_DRV.
module rgb_fade_pwm
  import rgb_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int PRESCALE   = 300000,
  parameter int PRESCALE_W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  rgb_fade_pwm_if.slave cmd,
  output logic         busy,
  output logic         done,
  output logic         pwm_red,
  output logic         pwm_green,
  output logic         pwm_blue
);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [0:0]            state_q, state_d;
  logic [PWM_BITS-1:0]   cur_q [NUM_CH];
  logic [PWM_BITS-1:0]   cur_d [NUM_CH];
  logic [PWM_BITS-1:0]   tgt_q [NUM_CH];
  logic [PWM_BITS-1:0]   tgt_d [NUM_CH];
  logic [PWM_BITS-1:0]   cmd_tgt [NUM_CH];
  logic                  tick;
  logic                  wrap;
  logic                  all_eq;
  logic                  done_c;
  logic [NUM_CH-1:0]     pwm_v;

  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    if (cur < tgt)      return cur + PWM_BITS'(1);
    else if (cur > tgt) return cur - PWM_BITS'(1);
    else                return cur;
  endfunction

  assign cmd_tgt[CH_RED]   = cmd.cmd_red;
  assign cmd_tgt[CH_GREEN] = cmd.cmd_green;
  assign cmd_tgt[CH_BLUE]  = cmd.cmd_blue;

  // Prescaler and PWM counter are free-running; commands never restart them
  assign tick      = (presc_q == PRESCALE_W'(PRESCALE - 1));
  assign presc_d   = tick ? '0 : presc_q + PRESCALE_W'(1);
  assign wrap      = &pwm_cnt_q;
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    all_eq  = 1'b1;
    done_c  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (cmd.cmd_valid) begin
        tgt_d = cmd_tgt;
        if (cmd.cmd_instant) cur_d   = cmd_tgt;
        else                 state_d = ST_FADE;
      end
    end else if (tick) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cur_d[ch] = step_toward(cur_q[ch], tgt_q[ch]);
        if (cur_d[ch] != tgt_q[ch]) all_eq = 1'b0;
      end
      // Exit on the tick that lands every channel, including a no-op command
      if (all_eq) begin
        state_d = ST_IDLE;
        done_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      state_q   <= ST_IDLE;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cur_q[ch] <= '0;
        tgt_q[ch] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_compare_ch #(
      .PWM_BITS (PWM_BITS)
    ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt_i (pwm_cnt_q),
      .wrap_i    (wrap),
      .duty_i    (cur_q[ch]),
      .pwm_o     (pwm_v[ch])
    );
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_FADE);
  assign done          = done_c;
  assign pwm_red       = pwm_v[CH_RED];
  assign pwm_green     = pwm_v[CH_GREEN];
  assign pwm_blue      = pwm_v[CH_BLUE];

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Bench for rgb_fade_pwm: table of colour commands, randomized fades checked
// against a distance-based model, and hand sequences for busy/reset corners.
module tb_rgb_fade_pwm;
  import rgb_fade_pwm_pkg::*;

  localparam int PB = 8;
  localparam int PS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, pwm_red, pwm_green, pwm_blue;

  rgb_fade_pwm_if #(.PWM_BITS(PB)) cmd_if ();

  rgb_fade_pwm #(
    .PWM_BITS   (PB),
    .PRESCALE   (PS),
    .PRESCALE_W (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd_if),
    .busy      (busy),
    .done      (done),
    .pwm_red   (pwm_red),
    .pwm_green (pwm_green),
    .pwm_blue  (pwm_blue)
  );

  always #5 clk = ~clk;

  // Position within the fade-tick period: a tick is due in cycles where this is PS-1
  int m_presc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_presc <= 0;
    else        m_presc <= (m_presc == PS - 1) ? 0 : m_presc + 1;
  end

  int errors = 0;
  int checks = 0;
  int m_cur[3];

  typedef struct {
    bit instant;
    int r, g, b;
    int exp_len;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_cur(input int ch);
    case (ch)
      0:       return int'(dut.cur_q[0]);
      1:       return int'(dut.cur_q[1]);
      default: return int'(dut.cur_q[2]);
    endcase
  endfunction

  function automatic int dut_tgt(input int ch);
    case (ch)
      0:       return int'(dut.tgt_q[0]);
      1:       return int'(dut.tgt_q[1]);
      default: return int'(dut.tgt_q[2]);
    endcase
  endfunction

  task automatic drive_cmd(input bit instant, input int r, input int g, input int b);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_instant = instant;
    cmd_if.cmd_red     = PB'(r);
    cmd_if.cmd_green   = PB'(g);
    cmd_if.cmd_blue    = PB'(b);
  endtask

  task automatic do_instant(input int r, input int g, input int b);
    int tg[3];
    tg[0] = r; tg[1] = g; tg[2] = b;
    drive_cmd(1'b1, r, g, b);
    chk("inst_ready", cmd_if.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("inst_busy", busy, 0);
    chk("inst_done", done, 0);
    for (int ch = 0; ch < 3; ch++) chk("inst_cur", dut_cur(ch), tg[ch]);
    m_cur = tg;
  endtask

  // Channel value after k ticks: moves toward target by one per tick, then holds
  task automatic do_fade(input int r, input int g, input int b, input int exp_len);
    int st[3];
    int tg[3];
    int L, k, cyc, d, e;
    bit tick_now;
    st = m_cur;
    tg[0] = r; tg[1] = g; tg[2] = b;
    if (exp_len >= 0) L = exp_len;
    else begin
      L = 1;
      for (int ch = 0; ch < 3; ch++) begin
        d = (tg[ch] > st[ch]) ? tg[ch] - st[ch] : st[ch] - tg[ch];
        if (d > L) L = d;
      end
    end
    drive_cmd(1'b0, r, g, b);
    chk("fade_accept_ready", cmd_if.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < L && cyc < 400) begin
      tick_now = (m_presc == PS - 1);
      chk("fade_busy", busy, 1);
      chk("fade_ready", cmd_if.cmd_ready, 0);
      for (int ch = 0; ch < 3; ch++) begin
        d = tg[ch] - st[ch];
        if (d >= 0) e = st[ch] + ((k < d) ? k : d);
        else        e = st[ch] - ((k < -d) ? k : -d);
        chk("fade_cur", dut_cur(ch), e);
      end
      chk("fade_done", done, (tick_now && (k + 1 == L)) ? 1 : 0);
      @(posedge clk);
      if (tick_now) k++;
      @(negedge clk);
      cyc++;
    end
    if (k < L) chk("fade_timeout", k, L);
    chk("fade_end_busy", busy, 0);
    chk("fade_end_ready", cmd_if.cmd_ready, 1);
    chk("fade_end_done", done, 0);
    for (int ch = 0; ch < 3; ch++) chk("fade_end_cur", dut_cur(ch), tg[ch]);
    m_cur = tg;
  endtask

  task automatic count_pwm(input int n, output int cr, output int cg, output int cb,
                           output int cbusy);
    cr = 0; cg = 0; cb = 0; cbusy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cr    += int'(pwm_red);
      cg    += int'(pwm_green);
      cb    += int'(pwm_blue);
      cbusy += int'(busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cr, cg, cb, cbusy, n_done, cyc;
    int sr, sg, sb, tr, tg, tb;

    vecs[0] = '{1'b1,   0,   0,   0, 0};
    vecs[1] = '{1'b0,   3,   0,   0, 3};
    vecs[2] = '{1'b1,  10,   0,   5, 0};
    vecs[3] = '{1'b0,   8,   3,   5, 3};
    vecs[4] = '{1'b0,   8,   3,   5, 1};
    vecs[5] = '{1'b0,   5,   6,   0, 5};
    vecs[6] = '{1'b1, 255, 255, 255, 0};
    vecs[7] = '{1'b0, 250, 255, 253, 5};

    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_instant = 1'b0;
    cmd_if.cmd_red     = '0;
    cmd_if.cmd_green   = '0;
    cmd_if.cmd_blue    = '0;
    m_cur = '{0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm_r", pwm_red, 0);
    chk("rst_pwm_g", pwm_green, 0);
    chk("rst_pwm_b", pwm_blue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    count_pwm(256, cr, cg, cb, cbusy);
    chk("rst_period_pwm", cr + cg + cb, 0);
    chk("rst_period_busy", cbusy, 0);

    // Instant colour, duty measured over one full period after settling
    do_instant(64, 0, 255);
    count_pwm(600, cr, cg, cb, cbusy);
    chk("inst_settle_busy", cbusy, 0);
    count_pwm(256, cr, cg, cb, cbusy);
    chk("duty_red", cr, 64);
    chk("duty_green", cg, 0);
    chk("duty_blue", cb, 255);
    chk("duty_busy", cbusy, 0);

    // Table of commands
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].instant) do_instant(vecs[i].r, vecs[i].g, vecs[i].b);
      else do_fade(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].exp_len);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Randomized start colours and small fades
    for (int i = 0; i < 12; i++) begin
      sr = $urandom_range(0, 255);
      sg = $urandom_range(0, 255);
      sb = $urandom_range(0, 255);
      do_instant(sr, sg, sb);
      tr = sr + $urandom_range(0, 12) - 6;
      tg = sg + $urandom_range(0, 12) - 6;
      tb = sb + $urandom_range(0, 12) - 6;
      tr = (tr < 0) ? 0 : (tr > 255) ? 255 : tr;
      tg = (tg < 0) ? 0 : (tg > 255) ? 255 : tg;
      tb = (tb < 0) ? 0 : (tb > 255) ? 255 : tb;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_fade(tr, tg, tb, -1);
    end

    // Command held during a fade waits for the first idle cycle
    do_instant(0, 0, 0);
    drive_cmd(1'b0, 4, 4, 4);
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b0, 200, 200, 200);
    n_done = 0;
    cyc = 0;
    while (n_done == 0 && cyc < 100) begin
      chk("hold_ready", cmd_if.cmd_ready, 0);
      chk("hold_tgt", dut_tgt(0), 4);
      if (done) n_done++;
      @(negedge clk);
      cyc++;
    end
    chk("hold_done_seen", n_done, 1);
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_ready", cmd_if.cmd_ready, 1);
    chk("hold_idle_cur", dut_cur(0), 4);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("hold_acc_busy", busy, 1);
    for (int ch = 0; ch < 3; ch++) chk("hold_acc_tgt", dut_tgt(ch), 200);

    // Async reset in the middle of that 4 -> 200 fade
    n_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n_done += int'(done);
    end
    chk("mid_no_done", n_done, 0);
    chk("mid_busy", busy, 1);
    chk("mid_cur_moved", (dut_cur(0) > 40) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", {pwm_red, pwm_green, pwm_blue}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    for (int ch = 0; ch < 3; ch++) chk("arst_cur", dut_cur(ch), 0);
    n_done = 0;
    repeat (4) begin
      @(negedge clk);
      n_done += int'(done);
    end
    chk("arst_no_done", n_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", cmd_if.cmd_ready, 1);
    m_cur = '{0, 0, 0};
    do_fade(2, 1, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
